// File: rtl/vga_dither_out.sv
// VGA output stage: ordered 2x2 Bayer dithering from IN_DEPTH to OUT_DEPTH bits
// per channel, sync delay matched to the two-stage colour pipeline, and a
// stretched design reset that stays high for RST_CYCLES cycles after release.
module vga_dither_out #(
    parameter int IN_DEPTH   = 6,
    parameter int OUT_DEPTH  = 4,
    parameter int DITHER     = 1,
    parameter int SYNC_POL   = 0,
    parameter int RST_CYCLES = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [IN_DEPTH-1:0]  in_r,
    input  logic [IN_DEPTH-1:0]  in_g,
    input  logic [IN_DEPTH-1:0]  in_b,
    input  logic                 in_hs,
    input  logic                 in_vs,
    output logic [OUT_DEPTH-1:0] out_r,
    output logic [OUT_DEPTH-1:0] out_g,
    output logic [OUT_DEPTH-1:0] out_b,
    output logic                 out_hs,
    output logic                 out_vs,
    output logic                 out_reset
);

    // Number of bits dropped per channel and width of the pre-shift sum.
    localparam int D  = IN_DEPTH - OUT_DEPTH;
    localparam int SW = IN_DEPTH + 1;
    // Left shift applied to the 2-bit Bayer value when D >= 2.
    localparam int SH = (D >= 2) ? (D - 2) : 0;
    localparam int CW = $clog2(RST_CYCLES + 1);

    localparam logic SYNC_ACT  = (SYNC_POL != 0) ? 1'b1 : 1'b0;
    localparam logic SYNC_IDLE = (SYNC_POL != 0) ? 1'b0 : 1'b1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(RST_CYCLES);

    // Bayer threshold for a 2x2 cell position, scaled to the dropped bits.
    function automatic logic [SW-1:0] thr_of(input logic [1:0] idx);
        logic [1:0]    bay;
        logic [SW-1:0] ext;
        case (idx)
            2'd0:    bay = 2'd0;
            2'd1:    bay = 2'd2;
            2'd2:    bay = 2'd3;
            2'd3:    bay = 2'd1;
            default: bay = 2'd0;
        endcase
        ext = SW'(bay);
        if (DITHER == 0 || D == 0) begin
            thr_of = '0;
        end else if (D == 1) begin
            thr_of = ext >> 1'b1;
        end else begin
            thr_of = ext << SH;
        end
    endfunction

    // Add threshold, drop D bits and clamp to full scale instead of wrapping.
    function automatic logic [OUT_DEPTH-1:0] dither_chan(input logic [IN_DEPTH-1:0] pix,
                                                         input logic [SW-1:0]       thr);
        logic [SW-1:0] sum;
        logic [SW-1:0] q;
        sum = {1'b0, pix} + thr;
        q   = sum >> D;
        if (|q[SW-1:OUT_DEPTH]) begin
            dither_chan = {OUT_DEPTH{1'b1}};
        end else begin
            dither_chan = q[OUT_DEPTH-1:0];
        end
    endfunction

    // Screen position parity and frame phase.
    logic x0_r;
    logic y0_r;
    logic f0_r;
    logic hs_d_r;
    logic vs_d_r;
    logic hs_edge_s;
    logic vs_edge_s;
    logic x0_next_s;
    logic y0_next_s;
    logic f0_next_s;
    logic [SW-1:0] thr_s;

    // Stage 1 registers.
    logic [IN_DEPTH-1:0] s1_red_r;
    logic [IN_DEPTH-1:0] s1_grn_r;
    logic [IN_DEPTH-1:0] s1_blu_r;
    logic [SW-1:0]       s1_thr_r;
    logic                s1_hs_r;
    logic                s1_vs_r;

    // Reset stretcher.
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;

    assign thr_s = thr_of({y0_r, (x0_r ^ f0_r)});

    // Detect inactive-to-active sync transitions against the previous cycle.
    always_comb begin
        hs_edge_s = 1'b0;
        vs_edge_s = 1'b0;
        if ((in_hs == SYNC_ACT) && (hs_d_r != SYNC_ACT)) begin
            hs_edge_s = 1'b1;
        end else begin
            hs_edge_s = 1'b0;
        end
        if ((in_vs == SYNC_ACT) && (vs_d_r != SYNC_ACT)) begin
            vs_edge_s = 1'b1;
        end else begin
            vs_edge_s = 1'b0;
        end
    end

    // Next column/row parity and frame phase; a vs edge overrides the row toggle.
    always_comb begin
        x0_next_s = ~x0_r;
        y0_next_s = y0_r;
        f0_next_s = f0_r;
        if (hs_edge_s) begin
            x0_next_s = 1'b0;
            y0_next_s = ~y0_r;
        end else begin
            x0_next_s = ~x0_r;
            y0_next_s = y0_r;
        end
        if (vs_edge_s) begin
            y0_next_s = 1'b0;
            f0_next_s = ~f0_r;
        end else begin
            f0_next_s = f0_r;
        end
    end

    // Position tracking and sync history registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            x0_r   <= 1'b0;
            y0_r   <= 1'b0;
            f0_r   <= 1'b0;
            hs_d_r <= SYNC_IDLE;
            vs_d_r <= SYNC_IDLE;
        end else begin
            x0_r   <= x0_next_s;
            y0_r   <= y0_next_s;
            f0_r   <= f0_next_s;
            hs_d_r <= in_hs;
            vs_d_r <= in_vs;
        end
    end

    // Stage 1: capture pixel, its threshold and the syncs.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_red_r <= '0;
            s1_grn_r <= '0;
            s1_blu_r <= '0;
            s1_thr_r <= '0;
            s1_hs_r  <= SYNC_IDLE;
            s1_vs_r  <= SYNC_IDLE;
        end else begin
            s1_red_r <= in_r;
            s1_grn_r <= in_g;
            s1_blu_r <= in_b;
            s1_thr_r <= thr_s;
            s1_hs_r  <= in_hs;
            s1_vs_r  <= in_vs;
        end
    end

    // Stage 2: register the dithered, saturated colour and the aligned syncs.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_r  <= '0;
            out_g  <= '0;
            out_b  <= '0;
            out_hs <= SYNC_IDLE;
            out_vs <= SYNC_IDLE;
        end else begin
            out_r  <= dither_chan(s1_red_r, s1_thr_r);
            out_g  <= dither_chan(s1_grn_r, s1_thr_r);
            out_b  <= dither_chan(s1_blu_r, s1_thr_r);
            out_hs <= s1_hs_r;
            out_vs <= s1_vs_r;
        end
    end

    // Stretcher countdown, holding at zero once expired.
    always_comb begin
        cnt_next_s = cnt_r;
        if (cnt_r != '0) begin
            cnt_next_s = cnt_r - CW'(1'b1);
        end else begin
            cnt_next_s = '0;
        end
    end

    // Reload the stretcher while reset is held; output follows the next count.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r     <= CNT_LOAD;
            out_reset <= 1'b1;
        end else begin
            cnt_r     <= cnt_next_s;
            out_reset <= (cnt_next_s != '0);
        end
    end

endmodule
